// File: rtl/fmul_normalize_round_pkg.sv
// fmul_normalize_round_pkg: shared FP32 classes, rounding modes and constants
package fmul_normalize_round_pkg;

    typedef enum logic [1:0] {
        NORMAL = 2'b00,
        ZERO   = 2'b01,
        INF    = 2'b10,
        NAN    = 2'b11
    } fp_class_e;

    typedef enum logic [2:0] {
        RNE = 3'b000,
        RTZ = 3'b001,
        RDN = 3'b010,
        RUP = 3'b011,
        RMM = 3'b100
    } round_mode_e;

    localparam logic [31:0] CANONICAL_NAN = 32'h7FC0_0000;
    localparam int          FP32_BIAS     = 127;

endpackage

// File: rtl/fmul_normalize_round_fp_rounder.sv
// fp_rounder: combinational significand rounding by RISC-V frm
module fp_rounder
    import fmul_normalize_round_pkg::*;
#(
    parameter int W = 24
) (
    input  logic         sign_i,
    input  logic [W-1:0] sig_i,
    input  logic         guard_i,
    input  logic         sticky_i,
    input  logic [2:0]   mode_i,
    output logic [W-1:0] sig_o,
    output logic         carry_o,
    output logic         inexact_o
);

    logic         up;
    logic [W-1:0] sum;

    // Round-up decision; reserved encodings fall through to nearest-even
    always_comb begin
        up = mode_i == RTZ ? 1'b0 :
             mode_i == RDN ? (guard_i | sticky_i) & sign_i :
             mode_i == RUP ? (guard_i | sticky_i) & ~sign_i :
             mode_i == RMM ? guard_i :
                             guard_i & (sticky_i | sig_i[0]);
    end

    assign {carry_o, sum} = {1'b0, sig_i} + {{W{1'b0}}, up};
    assign sig_o          = carry_o ? {1'b1, {(W-1){1'b0}}} : sum;
    assign inexact_o      = guard_i | sticky_i;

endmodule

// File: rtl/fmul_normalize_round.sv
// fmul_normalize_round: FP32 multiply post-stage (normalize, round, specials)
module fmul_normalize_round
    import fmul_normalize_round_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int EXP_W  = 8,
    parameter int MANT_W = 23,
    parameter int BIAS   = FP32_BIAS
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              clk_en_i,
    input  logic [2*XLEN-1:0] product_i,
    input  logic              product_valid_i,
    input  logic              sign_a_i,
    input  logic              sign_b_i,
    input  logic [EXP_W-1:0]  exp_a_i,
    input  logic [EXP_W-1:0]  exp_b_i,
    input  logic [1:0]        class_a_i,
    input  logic [1:0]        class_b_i,
    input  logic [2:0]        round_mode_i,
    output logic [31:0]       result_o,
    output logic              valid_o,
    output logic              invalid_o,
    output logic              overflow_o,
    output logic              underflow_o,
    output logic              inexact_o
);

    localparam int SW = MANT_W + 1;
    localparam int PW = 2 * SW;
    localparam int EW = EXP_W + 2;
    localparam logic [EW-1:0] EXP_MAX = EW'((1 << EXP_W) - 1);

    typedef enum logic [1:0] {IDLE, NORMALIZE, ROUND, VALID} state_e;

    state_e          state;
    logic [PW-1:0]   prod_q;
    logic            sign_a_q, sign_b_q;
    logic [EXP_W-1:0] exp_a_q, exp_b_q;
    logic [1:0]      class_a_q, class_b_q;
    logic [2:0]      mode_q;
    logic            sign_q, g_q, s_q;
    logic [EW-1:0]   exp_q;
    logic [SW-1:0]   sig_q;

    logic            top;
    logic [SW-1:0]   n_sig;
    logic            n_g, n_s;
    logic [EW-1:0]   n_exp;

    logic [SW-1:0]   r_sig;
    logic            r_carry, r_inexact;
    logic [EW-1:0]   r_exp;

    logic            a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic            inf_zero, special, ovf, unf, ovf_inf;
    logic [31:0]     res_d;

    logic            unused;
    assign unused = ^product_i[2*XLEN-1:PW];

    // Align the product so the hidden one sits at the significand MSB
    always_comb begin
        top   = prod_q[PW-1];
        n_sig = top ? prod_q[PW-1 -: SW] : prod_q[PW-2 -: SW];
        n_g   = top ? prod_q[PW-SW-1] : prod_q[PW-SW-2];
        n_s   = top ? |prod_q[PW-SW-2:0] : |prod_q[PW-SW-3:0];
        n_exp = {2'b00, exp_a_q} + {2'b00, exp_b_q} - EW'(BIAS) + {{(EW-1){1'b0}}, top};
    end

    fp_rounder #(.W(SW)) u_rounder (
        .sign_i    (sign_q),
        .sig_i     (sig_q),
        .guard_i   (g_q),
        .sticky_i  (s_q),
        .mode_i    (mode_q),
        .sig_o     (r_sig),
        .carry_o   (r_carry),
        .inexact_o (r_inexact)
    );

    // Resolve specials and range exceptions on the rounded value, by priority
    always_comb begin
        r_exp    = exp_q + {{(EW-1){1'b0}}, r_carry};
        a_nan    = class_a_q == NAN;
        b_nan    = class_b_q == NAN;
        a_inf    = class_a_q == INF;
        b_inf    = class_b_q == INF;
        a_zero   = class_a_q == ZERO;
        b_zero   = class_b_q == ZERO;
        inf_zero = (a_inf & b_zero) | (b_inf & a_zero);
        special  = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;
        ovf      = ~r_exp[EW-1] & (r_exp >= EXP_MAX);
        unf      = r_exp[EW-1] | (r_exp == '0);
        ovf_inf  = mode_q == RTZ ? 1'b0 :
                   mode_q == RDN ? sign_q :
                   mode_q == RUP ? ~sign_q : 1'b1;
        res_d    = (a_nan | b_nan | inf_zero) ? CANONICAL_NAN :
                   (a_inf | b_inf)            ? {sign_q, {EXP_W{1'b1}}, {MANT_W{1'b0}}} :
                   (a_zero | b_zero)          ? {sign_q, {(EXP_W+MANT_W){1'b0}}} :
                   ovf ? (ovf_inf ? {sign_q, {EXP_W{1'b1}}, {MANT_W{1'b0}}}
                                  : {sign_q, {(EXP_W-1){1'b1}}, 1'b0, {MANT_W{1'b1}}}) :
                   unf                        ? {sign_q, {(EXP_W+MANT_W){1'b0}}} :
                                                {sign_q, r_exp[EXP_W-1:0], r_sig[MANT_W-1:0]};
    end

    // Capture operands on the valid pulse, then register the normalized value
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            prod_q    <= '0;
            sign_a_q  <= 1'b0;
            sign_b_q  <= 1'b0;
            exp_a_q   <= '0;
            exp_b_q   <= '0;
            class_a_q <= '0;
            class_b_q <= '0;
            mode_q    <= '0;
            sign_q    <= 1'b0;
            exp_q     <= '0;
            sig_q     <= '0;
            g_q       <= 1'b0;
            s_q       <= 1'b0;
        end else if (clk_en_i) begin
            if (state == IDLE && product_valid_i) begin
                prod_q    <= product_i[PW-1:0];
                sign_a_q  <= sign_a_i;
                sign_b_q  <= sign_b_i;
                exp_a_q   <= exp_a_i;
                exp_b_q   <= exp_b_i;
                class_a_q <= class_a_i;
                class_b_q <= class_b_i;
                mode_q    <= round_mode_i;
            end
            if (state == NORMALIZE) begin
                sign_q <= sign_a_q ^ sign_b_q;
                exp_q  <= n_exp;
                sig_q  <= n_sig;
                g_q    <= n_g;
                s_q    <= n_s;
            end
        end
    end

    // Sequence the stage and register result/flags on the ROUND->VALID edge
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state       <= IDLE;
            result_o    <= '0;
            valid_o     <= 1'b0;
            invalid_o   <= 1'b0;
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
            inexact_o   <= 1'b0;
        end else if (clk_en_i) begin
            case (state)
                IDLE:      state <= product_valid_i ? NORMALIZE : IDLE;
                NORMALIZE: state <= ROUND;
                ROUND: begin
                    state       <= VALID;
                    valid_o     <= 1'b1;
                    result_o    <= res_d;
                    invalid_o   <= inf_zero;
                    overflow_o  <= ~special & ovf;
                    underflow_o <= ~special & ~ovf & unf;
                    inexact_o   <= ~special & (ovf | unf | r_inexact);
                end
                default: begin
                    state   <= IDLE;
                    valid_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
